// File: rtl/exu_muldiv_pkg.sv
// Shared types and op-decode helpers for the sequential RV64M multiply/divide unit.
package exu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return (op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU});
  endfunction

  function automatic logic is_rem(input muldiv_op_e op);
    return (op inside {OP_REM, OP_REMU});
  endfunction

  // Plain MUL only keeps the low half, so its signedness is irrelevant; treat it as signed.
  function automatic logic src1_signed(input muldiv_op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
  endfunction

  function automatic logic src2_signed(input muldiv_op_e op);
    return (op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM});
  endfunction

endpackage

// File: rtl/exu_muldiv_seq_if.sv
// Request/response bundle between the execute stage (master) and the mul/div sequencer (slave).
interface exu_muldiv_seq_if #(
  parameter int XLEN = 64
) ();

  logic                      in_valid;
  logic                      in_ready;
  exu_muldiv_pkg::muldiv_op_e in_op;
  logic                      in_word;
  logic [XLEN-1:0]           in_src1;
  logic [XLEN-1:0]           in_src2;
  logic                      flush;
  logic                      out_valid;
  logic                      out_ready;
  logic [XLEN-1:0]           out_result;
  logic                      busy;

  modport master (
    output in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_word, in_src1, in_src2, flush, out_ready,
    output in_ready, out_valid, out_result, busy
  );

endinterface

// File: rtl/exu_muldiv_seq_core_step.sv
// One radix-2 iteration: shift-add multiply step or restoring-divide step on a {hi, lo} pair.
module muldiv_core_step #(
  parameter int XLEN = 64
) (
  input  logic            i_div_mode,
  input  logic [XLEN-1:0] i_hi,
  input  logic [XLEN-1:0] i_lo,
  input  logic [XLEN-1:0] i_opnd,
  output logic [XLEN-1:0] o_hi,
  output logic [XLEN-1:0] o_lo
);

  logic [XLEN:0] w_sum;
  logic [XLEN:0] w_shifted;
  logic [XLEN:0] w_diff;
  logic          w_fits;

  always_comb begin
    w_sum     = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_opnd} : {(XLEN+1){1'b0}});
    w_shifted = {i_hi, i_lo[XLEN-1]};
    // Remainder is always below the divisor, so the top bit of the difference is a clean borrow.
    w_diff    = w_shifted - {1'b0, i_opnd};
    w_fits    = ~w_diff[XLEN];

    o_hi = w_sum[XLEN:1];
    o_lo = {w_sum[0], i_lo[XLEN-1:1]};
    if (i_div_mode) begin
      o_hi = w_fits ? w_diff[XLEN-1:0] : w_shifted[XLEN-1:0];
      o_lo = {i_lo[XLEN-2:0], w_fits};
    end
  end

endmodule

// File: rtl/exu_muldiv_seq.sv
// Multi-cycle RV64M multiply/divide sequencer: one bit per cycle, sign fix-up, result held until consumed.
module exu_muldiv_seq
  import exu_muldiv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input logic             clk,
  input logic             rst,
  exu_muldiv_seq_if.slave bus
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_W = {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}};

  function automatic logic [XLEN-1:0] word_ext(input logic [XLEN-1:0] v, input logic sgn);
    return {{HALF{sgn & v[HALF-1]}}, v[HALF-1:0]};
  endfunction

  function automatic logic [XLEN-1:0] fit_word(input logic [XLEN-1:0] v, input logic word);
    return word ? word_ext(v, 1'b1) : v;
  endfunction

  muldiv_state_e   r_state;
  muldiv_state_e   w_state_next;
  muldiv_op_e      r_op;
  logic            r_word;
  logic            r_neg_res;
  logic            r_neg_rem;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_opnd;
  logic [XLEN-1:0] r_result;
  logic [CW-1:0]   r_cnt;

  logic            w_accept;
  logic            w_div_op;
  logic            w_rem_op;
  logic            w_s1_neg;
  logic            w_s2_neg;
  logic            w_div_zero;
  logic            w_div_ovf;
  logic            w_special;
  logic            w_iterating;
  logic [XLEN-1:0] w_ext1;
  logic [XLEN-1:0] w_ext2;
  logic [XLEN-1:0] w_mag1;
  logic [XLEN-1:0] w_mag2;
  logic [XLEN-1:0] w_special_raw;
  logic [XLEN-1:0] w_special_res;
  logic [XLEN-1:0] w_step_hi;
  logic [XLEN-1:0] w_step_lo;
  logic [2*XLEN-1:0] w_prod_norm;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0] w_quot_fix;
  logic [XLEN-1:0] w_rem_fix;
  logic [XLEN-1:0] w_sel;
  logic [XLEN-1:0] w_fix_res;

  // Operand conditioning on the request side
  assign w_div_op = is_div(bus.in_op);
  assign w_rem_op = is_rem(bus.in_op);
  assign w_ext1   = bus.in_word ? word_ext(bus.in_src1, src1_signed(bus.in_op)) : bus.in_src1;
  assign w_ext2   = bus.in_word ? word_ext(bus.in_src2, src2_signed(bus.in_op)) : bus.in_src2;
  assign w_s1_neg = src1_signed(bus.in_op) & w_ext1[XLEN-1];
  assign w_s2_neg = src2_signed(bus.in_op) & w_ext2[XLEN-1];
  assign w_mag1   = w_s1_neg ? (~w_ext1 + 1'b1) : w_ext1;
  assign w_mag2   = w_s2_neg ? (~w_ext2 + 1'b1) : w_ext2;

  assign w_div_zero = w_div_op & (w_ext2 == '0);
  assign w_div_ovf  = w_div_op & src2_signed(bus.in_op) & (&w_ext2)
                    & (w_ext1 == (bus.in_word ? MIN_W : MIN_D));
  assign w_special  = w_div_zero | w_div_ovf;

  // Divide-by-zero takes priority over overflow; both bypass the iteration entirely.
  assign w_special_raw = w_div_zero ? (w_rem_op ? w_ext1 : {XLEN{1'b1}})
                                    : (w_rem_op ? {XLEN{1'b0}} : w_ext1);
  assign w_special_res = fit_word(w_special_raw, bus.in_word);

  assign w_accept    = (r_state == ST_IDLE) & bus.in_valid & ~bus.flush;
  assign w_iterating = (r_state == ST_MUL) | (r_state == ST_DIV);

  muldiv_core_step #(
    .XLEN(XLEN)
  ) u_step (
    .i_div_mode(r_state == ST_DIV),
    .i_hi      (r_hi),
    .i_lo      (r_lo),
    .i_opnd    (r_opnd),
    .o_hi      (w_step_hi),
    .o_lo      (w_step_lo)
  );

  // Word multiplies run half the iterations, leaving the product shifted up by HALF.
  assign w_prod_norm = r_word ? {{HALF{1'b0}}, r_hi, r_lo[XLEN-1:HALF]} : {r_hi, r_lo};
  assign w_prod_fix  = r_neg_res ? (~w_prod_norm + 1'b1) : w_prod_norm;
  assign w_quot_fix  = r_neg_res ? (~r_lo + 1'b1) : r_lo;
  assign w_rem_fix   = r_neg_rem ? (~r_hi + 1'b1) : r_hi;

  always_comb begin
    w_sel = w_rem_fix;
    case (r_op)
      OP_MUL:                       w_sel = w_prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_sel = w_prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              w_sel = w_quot_fix;
      default:                      w_sel = w_rem_fix;
    endcase
  end

  assign w_fix_res = fit_word(w_sel, r_word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (bus.flush) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            if (w_special)     w_state_next = ST_DONE;
            else if (w_div_op) w_state_next = ST_DIV;
            else               w_state_next = ST_MUL;
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt == '0) w_state_next = ST_FIX;
        end
        ST_FIX:  w_state_next = ST_DONE;
        ST_DONE: begin
          if (bus.out_ready) w_state_next = ST_IDLE;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_MUL;
      r_word    <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_opnd    <= '0;
      r_result  <= '0;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_op      <= bus.in_op;
      r_word    <= bus.in_word;
      r_neg_res <= w_s1_neg ^ w_s2_neg;
      r_neg_rem <= w_s1_neg;
      r_hi      <= '0;
      r_cnt     <= bus.in_word ? CW'(HALF - 1) : CW'(XLEN - 1);
      if (w_div_op) begin
        // Word dividends sit in the upper half so the MSB-first shift reaches them immediately.
        r_lo   <= bus.in_word ? {w_mag1[HALF-1:0], {HALF{1'b0}}} : w_mag1;
        r_opnd <= w_mag2;
      end else begin
        r_lo   <= w_mag2;
        r_opnd <= w_mag1;
      end
      if (w_special) begin
        r_result <= w_special_res;
      end
    end else if (w_iterating) begin
      r_hi  <= w_step_hi;
      r_lo  <= w_step_lo;
      r_cnt <= r_cnt - 1'b1;
    end else if ((r_state == ST_FIX) && !bus.flush) begin
      r_result <= w_fix_res;
    end
  end

  assign bus.in_ready   = (r_state == ST_IDLE);
  assign bus.out_valid  = (r_state == ST_DONE);
  assign bus.busy       = (r_state != ST_IDLE);
  assign bus.out_result = r_result;

endmodule

// File: tb/tb_exu_muldiv_seq.sv
// Bench for exu_muldiv_seq: directed cases, handshake/flush/reset scenarios and randomized ops vs. a reference model.
module tb_exu_muldiv_seq;
  import exu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  exu_muldiv_seq_if #(.XLEN(64)) bus ();

  exu_muldiv_seq #(.XLEN(64)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [63:0] sext_w(input logic [63:0] x);
    return {{32{x[31]}}, x[31:0]};
  endfunction

  // RISC-V M semantics straight from the arithmetic definitions.
  function automatic logic [63:0] ref_model(input muldiv_op_e op, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
    logic [63:0]  x, y, r;
    logic [127:0] p;
    longint       sx, sy;
    logic         s1, s2;
    s1 = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    s2 = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    x = a;
    y = b;
    if (w) begin
      x = s1 ? sext_w(a) : {32'b0, a[31:0]};
      y = s2 ? sext_w(b) : {32'b0, b[31:0]};
    end
    sx = longint'(x);
    sy = longint'(y);
    r = '0;
    case (op)
      OP_MUL:    r = x * y;
      OP_MULH:   begin p = {{64{x[63]}}, x} * {{64{y[63]}}, y}; r = p[127:64]; end
      OP_MULHSU: begin p = {{64{x[63]}}, x} * {64'b0, y};       r = p[127:64]; end
      OP_MULHU:  begin p = {64'b0, x} * {64'b0, y};             r = p[127:64]; end
      OP_DIV: begin
        if (y == 64'd0) r = '1;
        else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
        else r = sx / sy;
      end
      OP_DIVU: r = (y == 64'd0) ? '1 : x / y;
      OP_REM: begin
        if (y == 64'd0) r = x;
        else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
        else r = sx % sy;
      end
      default: r = (y == 64'd0) ? x : x % y;
    endcase
    return w ? sext_w(r) : r;
  endfunction

  // Cycles from the accept edge to the first cycle with out_valid.
  function automatic int exp_lat(input muldiv_op_e op, input logic w,
                                 input logic [63:0] a, input logic [63:0] b);
    logic div_op, sdiv, zero, ovf;
    div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    sdiv   = (op == OP_DIV) || (op == OP_REM);
    zero   = div_op && (w ? (b[31:0] == 32'd0) : (b == 64'd0));
    ovf    = sdiv && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                        : (a == 64'h8000_0000_0000_0000 && b == '1));
    if (zero || ovf) return 1;
    return w ? 34 : 66;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 6))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'($urandom_range(0, 1000));
      4:       return {$urandom, 32'h8000_0000};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic issue(input muldiv_op_e op, input logic w, input logic [63:0] a, input logic [63:0] b);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_word  = w;
    bus.in_src1  = a;
    bus.in_src2  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_op    = muldiv_op_e'($urandom_range(0, 7));
    bus.in_word  = 1'($urandom_range(0, 1));
    bus.in_src1  = {$urandom, $urandom};
    bus.in_src2  = {$urandom, $urandom};
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 1;
    while (bus.out_valid !== 1'b1 && cyc < 300) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_op     = OP_MUL;
    bus.in_word   = 1'b0;
    bus.in_src1   = '0;
    bus.in_src2   = '0;
    #1 rst = 1'b1;
    #2;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.out_result !== 64'd0) begin n_bad++; $display("FAIL reset_out_result: got %h want 0", bus.out_result); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_directed();
    muldiv_op_e  ops [8] = '{OP_DIV, OP_REM, OP_MULHU, OP_MUL, OP_MUL, OP_DIVU, OP_DIV, OP_REM};
    logic        wv  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [63:0] av  [8] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FFF9, '1, '1,
                             64'h0000_0000_7FFF_FFFF, 64'h0000_0000_0000_1234,
                             64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] bv  [8] = '{64'd2, 64'd2, '1, '1, 64'd2, 64'd0, '1, '1};
    logic [63:0] ev  [8] = '{64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'h8000_0000_0000_0000, 64'h0000_0000_0000_0000};
    int          lv  [8] = '{66, 66, 66, 66, 34, 1, 1, 1};
    int cyc;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], wv[i], av[i], bv[i]);
      wait_valid(cyc);
      $display("directed %0d %s w=%0b a=%h b=%h -> %h after %0d cycles",
               i, ops[i].name(), wv[i], av[i], bv[i], bus.out_result, cyc);
      n_cmp++; if (cyc != lv[i]) begin n_bad++; $display("FAIL directed_%0d_latency: got %0d want %0d", i, cyc, lv[i]); end
      n_cmp++; if (bus.out_result !== ev[i]) begin n_bad++; $display("FAIL directed_%0d_result: got %h want %h", i, bus.out_result, ev[i]); end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a, b, e;
    int cyc;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    e = ref_model(OP_MULH, 1'b0, a, b);
    issue(OP_MULH, 1'b0, a, b);
    wait_valid(cyc);
    n_cmp++; if (bus.out_result !== e) begin n_bad++; $display("FAIL bp_result: got %h want %h", bus.out_result, e); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_valid_%0d: got %b want 1", k, bus.out_valid); end
      n_cmp++; if (bus.out_result !== e) begin n_bad++; $display("FAIL bp_hold_result_%0d: got %h want %h", k, bus.out_result, e); end
    end
    consume();
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_after: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_out_valid_after: got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    int seen;
    int cyc;
    issue(OP_DIV, 1'b0, {$urandom, $urandom}, {$urandom, $urandom} | 64'd1);
    repeat (9) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", bus.busy); end
    seen = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); end
    // flush together with a request in IDLE must not accept it
    bus.in_valid = 1'b1;
    bus.in_op    = OP_MULHU;
    bus.flush    = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL flush_idle_accept: busy %b want 0", bus.busy); end
    // flush beats out_ready in DONE
    issue(OP_DIVU, 1'b0, 64'd55, 64'd0);
    wait_valid(cyc);
    n_cmp++; if (cyc != 1) begin n_bad++; $display("FAIL flush_done_latency: got %0d want 1", cyc); end
    bus.flush     = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_done_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL flush_done_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_async_reset();
    int cyc;
    issue(OP_MUL, 1'b0, {$urandom, $urandom}, {$urandom, $urandom});
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL arst_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL arst_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    issue(OP_DIVU, 1'b0, 64'd100, 64'd7);
    wait_valid(cyc);
    $display("post-reset DIVU 100/7 -> %0d after %0d cycles", bus.out_result, cyc);
    n_cmp++; if (cyc != 66) begin n_bad++; $display("FAIL arst_divu_latency: got %0d want 66", cyc); end
    n_cmp++; if (bus.out_result !== 64'd14) begin n_bad++; $display("FAIL arst_divu_result: got %0d want 14", bus.out_result); end
    consume();
  endtask

  task automatic test_random();
    muldiv_op_e  op;
    logic        w;
    logic [63:0] a, b, e;
    int          lat, cyc;
    for (int t = 0; t < 40; t++) begin
      op = muldiv_op_e'($urandom_range(0, 7));
      w  = (op inside {OP_MULH, OP_MULHSU, OP_MULHU}) ? 1'b0 : 1'($urandom_range(0, 1));
      a  = rand64();
      b  = rand64();
      e  = ref_model(op, w, a, b);
      lat = exp_lat(op, w, a, b);
      issue(op, w, a, b);
      wait_valid(cyc);
      $display("rand %0d %s w=%0b a=%h b=%h -> %h after %0d cycles",
               t, op.name(), w, a, b, bus.out_result, cyc);
      n_cmp++; if (cyc != lat) begin n_bad++; $display("FAIL rand_%0d_latency: got %0d want %0d", t, cyc, lat); end
      n_cmp++; if (bus.out_result !== e) begin n_bad++; $display("FAIL rand_%0d_result: got %h want %h", t, bus.out_result, e); end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      consume();
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] a1, b1, e1, a2, b2, e2;
    int cyc;
    a1 = {$urandom, $urandom};
    b1 = {$urandom, $urandom};
    a2 = {$urandom, $urandom};
    b2 = {32'd0, $urandom} | 64'd1;
    e1 = ref_model(OP_MULHU, 1'b0, a1, b1);
    e2 = ref_model(OP_DIVU, 1'b0, a2, b2);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_op     = OP_MULHU;
    bus.in_word   = 1'b0;
    bus.in_src1   = a1;
    bus.in_src2   = b1;
    @(posedge clk);
    #1;
    bus.in_op   = OP_DIVU;
    bus.in_src1 = a2;
    bus.in_src2 = b2;
    wait_valid(cyc);
    $display("b2b first MULHU -> %h after %0d cycles", bus.out_result, cyc);
    n_cmp++; if (cyc != 66) begin n_bad++; $display("FAIL b2b_first_latency: got %0d want 66", cyc); end
    n_cmp++; if (bus.out_result !== e1) begin n_bad++; $display("FAIL b2b_first_result: got %h want %h", bus.out_result, e1); end
    @(posedge clk);
    #1;
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_busy: got %b want 0", bus.busy); end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.busy !== 1'b1) begin n_bad++; $display("FAIL b2b_second_accept: busy %b want 1", bus.busy); end
    wait_valid(cyc);
    $display("b2b second DIVU -> %h after %0d cycles", bus.out_result, cyc);
    n_cmp++; if (cyc != 66) begin n_bad++; $display("FAIL b2b_second_latency: got %0d want 66", cyc); end
    n_cmp++; if (bus.out_result !== e2) begin n_bad++; $display("FAIL b2b_second_result: got %h want %h", bus.out_result, e2); end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exu_muldiv_seq.md
Name: exu_muldiv_seq

Overview:
- Multi-cycle sequencer for RV64M multiply/divide. Replaces the single-cycle combinational `*`, `/` and `%` paths in the execute stage.
- Accepts one operation via a valid/ready handshake and iterates a radix-2 shift-add multiplier or a restoring divider, one bit per cycle.
- Applies sign fix-up, then holds the result until the pipeline consumes it.
- Execute stalls while the unit is busy. A pipeline flush aborts the operation in flight.

Parameters:
- XLEN, 64, datapath width. Word ops use XLEN/2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation request
- in_ready  out  1  unit can accept (IDLE state)
- in_op  in  3  MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, encoded in the package
- in_word  in  1  W-variant (MULW/DIVW/DIVUW/REMW/REMUW)
- in_src1  in  XLEN  operand 1, already forwarded
- in_src2  in  XLEN  operand 2, already forwarded
- flush  in  1  abort; return to IDLE
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- out_result  out  XLEN  final result, sign-extended for W ops
- busy  out  1  state != IDLE; drives the execute-stage stall

Behaviour:
- Reset (async):
  - state = IDLE; in_ready = 1; out_valid = 0; out_result = 0; busy = 0.
  - All internal registers are cleared.
  - Reset mid-operation discards the operation with no output.
- States:
  - IDLE: in_ready = 1.
  - MUL: N iterations.
  - DIV: N iterations.
  - FIX: one cycle of sign correction and result select.
  - DONE: out_valid = 1.
- Iteration count: N = XLEN for normal ops, XLEN/2 for in_word. The iteration counter counts down from N-1 to 0.
- Accept: in_valid & in_ready & !flush at edge T.
  - Operands are latched; word ops take the low 32 bits, sign- or zero-extended per the op.
  - Magnitudes are latched: negative signed operands are negated. MULHSU treats only src1 as signed.
  - Result-sign and remainder-sign flags are latched.
- MUL iteration:
  - If multiplier LSB = 1, add the multiplicand to the upper half of the 2·XLEN accumulator.
  - Shift the accumulator right by 1 (carry kept).
- DIV iteration:
  - Shift {rem, quot} left by 1.
  - Trial-subtract the divisor from rem. If non-negative, keep the difference and set quot LSB = 1.
- FIX: negate the 2·XLEN product, quotient or remainder if its latched sign flag is set.
- Result select:
  - MUL: low half of the product.
  - MULH*: high half of the product.
  - DIV*: quotient.
  - REM*: remainder.
  - W ops: sign-extend bit 31 of the selected value.
- Normal latency: state is MUL/DIV from T+1 to T+N, FIX at T+N+1, out_valid high from T+N+2.
- Special cases, detected at accept; skip iteration and enter DONE at T+1:
  - Divide by zero: DIV/DIVU give all ones; REM/REMU give the dividend (W: sign-extended low 32).
  - Signed overflow (most-negative ÷ −1): DIV gives the dividend; REM gives 0.
- DONE:
  - out_valid and out_result are held stable until out_ready.
  - On out_valid & out_ready: go to IDLE next cycle. in_ready rises the cycle after the handshake; there is no same-cycle re-accept.
- flush:
  - In any state, the next edge sets state = IDLE and out_valid = 0, and the result is dropped.
  - flush & in_valid in IDLE: no accept.
  - flush wins over out_ready in DONE; the result is dropped.
- No new request is accepted while busy; in_op and operand changes have no effect.
- The result register updates only on FIX entry or special-case entry.

Decomposition:
- Package exu_muldiv_pkg:
  - op encoding enum: MUL = 0, MULH = 1, MULHSU = 2, MULHU = 3, DIV = 4, DIVU = 5, REM = 6, REMU = 7.
  - state enum.
  - helpers: is_div(op), src1_signed(op), src2_signed(op).
- One sub-module, muldiv_core_step: the combinational single-iteration datapath (shift-add step and restoring-subtract step), selected by a mode bit.
- The top level owns the FSM, counter, sign flags, fix-up and handshake.

Test Plan:
- DIV: src1 = 0xFFFF_FFFF_FFFF_FFF9 (−7), src2 = 2, accepted at T.
  - out_valid at T+66, result 0xFFFF_FFFF_FFFF_FFFD (−3).
  - REM with the same operands gives 0xFFFF_FFFF_FFFF_FFFF (−1).
- MULHU: src1 = src2 = 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE at T+66.
  - MUL with the same operands → 0x0000_0000_0000_0001.
- MULW: src1 = 0x7FFF_FFFF, src2 = 2 → 0xFFFF_FFFF_FFFF_FFFE at T+34.
- DIVU: src2 = 0 → 0xFFFF_FFFF_FFFF_FFFF with out_valid at T+1.
  - DIV 0x8000_0000_0000_0000 ÷ 0xFFFF_FFFF_FFFF_FFFF → 0x8000_0000_0000_0000 at T+1.
  - REM with the same operands → 0.
- Backpressure and flush:
  - With out_ready = 0 for 5 cycles, out_valid and out_result stay stable; out_ready = 1 gives in_ready = 1 next cycle.
  - flush at T+10 during DIV → IDLE at T+11 and no out_valid ever.
- Async reset:
  - rst pulsed mid-MUL (between edges) → in_ready = 1 and out_valid = 0 immediately.
  - A following DIVU 100 ÷ 7 gives 14.
